gpu_mem_arbiter: RTL and testbench

GPU_MEM_ARBITER -- requirements
Module: gpu_mem_arbiter

---
 rtl/gpu_mem_arbiter.sv | 92 +++++++++
 tb/tb_gpu_mem_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_mem_arbiter.sv
// gpu_mem_arbiter: core/host arbiter driving one shared multi-lane data memory port.
// Define GPU_ARB_ROUND_ROBIN_EN for round-robin IDLE ties and MAXHOLD core preemption.
module gpu_mem_arbiter #(
  parameter int AW = 10,
  parameter int DW = 18,
  parameter int LANES = 3,
  parameter int MAXHOLD = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [LANES*AW-1:0]   core_addr,
  input  logic [LANES*DW-1:0]   core_wdata,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [LANES*AW-1:0]   host_addr,
  input  logic [LANES*DW-1:0]   host_wdata,
  input  logic [4:0]            host_len,
  output logic                  core_gnt,
  output logic                  host_gnt,
  output logic                  core_stall,
  output logic                  core_rvalid,
  output logic                  host_rvalid,
  output logic [LANES*AW-1:0]   mem_addr,
  output logic [LANES*DW-1:0]   mem_wdata,
  output logic                  mem_we
);
  typedef enum logic [1:0] {IDLE, GRANT_CORE, GRANT_HOST} state_t;
  state_t state;
  logic [4:0] beat_cnt;
  logic [4:0] len_eff;
  logic tie_host;
  logic preempt;
  assign core_gnt = state == GRANT_CORE;
  assign host_gnt = state == GRANT_HOST;
  assign core_stall = core_req & ~core_gnt;
  assign len_eff = host_len == 5'd0 ? 5'd1 : host_len;
  assign mem_addr = core_gnt ? core_addr : host_gnt ? host_addr : '0;
  assign mem_wdata = core_gnt ? core_wdata : host_gnt ? host_wdata : '0;
  assign mem_we = core_gnt ? core_we & core_req : host_gnt ? host_we & host_req : 1'b0;
`ifdef GPU_ARB_ROUND_ROBIN_EN
  localparam int HW = $clog2(MAXHOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAXHOLD - 1);
  logic [HW-1:0] hold_cnt;
  logic last_host;
  assign tie_host = ~last_host;
  assign preempt = host_req && hold_cnt == HOLD_MAX;
  // hold_cnt saturates so a host arriving late into a long core run is admitted at once
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      hold_cnt <= '0;
      last_host <= 1'b1;
    end else begin
      hold_cnt <= (core_gnt && core_req && !preempt) ? (hold_cnt == HOLD_MAX ? hold_cnt : hold_cnt + 1'b1) : '0;
      if (core_gnt && (!core_req || preempt)) last_host <= 1'b0;
      else if (host_gnt && (!host_req || beat_cnt == 5'd1)) last_host <= 1'b1;
    end
`else
  assign tie_host = 1'b0;
  assign preempt = 1'b0;
`endif
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      beat_cnt <= '0;
      core_rvalid <= 1'b0;
      host_rvalid <= 1'b0;
    end else begin
      core_rvalid <= core_gnt & core_req & ~core_we;
      host_rvalid <= host_gnt & host_req & ~host_we;
      case (state)
        IDLE:
          if (core_req && !(host_req && tie_host)) state <= GRANT_CORE;
          else if (host_req) begin
            state <= GRANT_HOST;
            beat_cnt <= len_eff;
          end
        GRANT_CORE:
          if (!core_req) state <= IDLE;
          else if (preempt) begin
            state <= GRANT_HOST;
            beat_cnt <= len_eff;
          end
        GRANT_HOST: begin
          if (host_req) beat_cnt <= beat_cnt - 5'd1;
          if (!host_req || beat_cnt == 5'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// tb_gpu_mem_arbiter: directed scenarios plus randomized traffic against a behavioural arbiter model.
module tb_gpu_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 18;
  localparam int LANES = 3;
  localparam int MAXHOLD = 16;
`ifdef GPU_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic core_req = 1'b0, core_we = 1'b0, host_req = 1'b0, host_we = 1'b0;
  logic [LANES*AW-1:0] core_addr = '0, host_addr = '0;
  logic [LANES*DW-1:0] core_wdata = '0, host_wdata = '0;
  logic [4:0] host_len = 5'd1;
  logic core_gnt, host_gnt, core_stall, core_rvalid, host_rvalid, mem_we;
  logic [LANES*AW-1:0] mem_addr;
  logic [LANES*DW-1:0] mem_wdata;
  int checks = 0;
  int errors = 0;
  int m_owner, m_run, m_left;
  bit m_last_host, m_crv, m_hrv;

  always #5 CLK = ~CLK;

  gpu_mem_arbiter #(.AW(AW), .DW(DW), .LANES(LANES), .MAXHOLD(MAXHOLD)) dut (
    .CLK(CLK), .RST(RST),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_len(host_len),
    .core_gnt(core_gnt), .host_gnt(host_gnt), .core_stall(core_stall),
    .core_rvalid(core_rvalid), .host_rvalid(host_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    core_req = 1'b1;
    tick;
    checks++;
    if ({core_gnt, host_gnt, core_rvalid, host_rvalid, mem_we} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000", {core_gnt, host_gnt, core_rvalid, host_rvalid, mem_we});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_mem got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    end
    checks++;
    if (core_stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall got %b want 1", core_stall);
    end
    core_req = 1'b0;
    #1;
    checks++;
    if (core_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall_low got %b want 0", core_stall);
    end
    RST = 1'b0;
    tick;
  endtask

  task automatic test_core_read;
    logic [LANES*AW-1:0] a;
    a = {AW'(5), AW'(6), AW'(7)};
    core_addr = a;
    core_we = 1'b0;
    core_req = 1'b1;
    #1;
    checks++;
    if (core_gnt !== 1'b0) begin
      errors++;
      $display("FAIL read_c0_gnt got %b want 0", core_gnt);
    end
    tick;
    checks++;
    if (core_gnt !== 1'b1 || host_gnt !== 1'b0 || mem_addr !== a || mem_we !== 1'b0 || core_stall !== 1'b0) begin
      errors++;
      $display("FAIL read_c1 got gnt=%b%b addr=%h we=%b stall=%b want 10 %h 0 0", core_gnt, host_gnt, mem_addr, mem_we, core_stall, a);
    end
    tick;
    core_req = 1'b0;
    #1;
    checks++;
    if (core_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL read_c2_rvalid got %b want 1", core_rvalid);
    end
    tick;
    checks++;
    if (core_gnt !== 1'b0 || core_rvalid !== 1'b0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL read_c3_idle got gnt=%b rvalid=%b addr=%h want 0 0 0", core_gnt, core_rvalid, mem_addr);
    end
  endtask

  task automatic test_tie;
    RST = 1'b1;
    #1;
    RST = 1'b0;
    tick;
    core_req = 1'b1;
    core_we = 1'b0;
    host_req = 1'b1;
    host_we = 1'b0;
    host_len = 5'd1;
    tick;
    checks++;
    if (core_gnt !== 1'b1 || host_gnt !== 1'b0) begin
      errors++;
      $display("FAIL tie_first got gnt=%b%b want 10", core_gnt, host_gnt);
    end
    tick;
    tick;
    tick;
    core_req = 1'b0;
    #1;
    checks++;
    if (host_gnt !== 1'b0) begin
      errors++;
      $display("FAIL tie_drop_host got %b want 0", host_gnt);
    end
    tick;
    checks++;
    if (core_gnt !== 1'b0 || host_gnt !== 1'b0) begin
      errors++;
      $display("FAIL tie_idle got gnt=%b%b want 00", core_gnt, host_gnt);
    end
    tick;
    checks++;
    if (host_gnt !== 1'b1 || core_gnt !== 1'b0) begin
      errors++;
      $display("FAIL tie_host got gnt=%b%b want 01", core_gnt, host_gnt);
    end
    tick;
    host_req = 1'b0;
    #1;
    checks++;
    if (host_rvalid !== 1'b1 || host_gnt !== 1'b0) begin
      errors++;
      $display("FAIL tie_host_rvalid got rvalid=%b gnt=%b want 1 0", host_rvalid, host_gnt);
    end
    tick;
  endtask

  task automatic test_host_burst;
    host_req = 1'b1;
    host_we = 1'b1;
    host_len = 5'd4;
    host_addr = '0;
    tick;
    for (int i = 0; i < 4; i++) begin
      host_addr = {LANES{AW'(i)}};
      host_wdata = {$urandom, $urandom};
      core_req = 1'b1;
      #1;
      checks++;
      if (host_gnt !== 1'b1 || mem_we !== 1'b1 || core_stall !== 1'b1 || mem_addr !== host_addr || mem_wdata !== host_wdata) begin
        errors++;
        $display("FAIL burst_beat%0d got gnt=%b we=%b stall=%b addr=%h wdata=%h want 1 1 1 %h %h", i, host_gnt, mem_we, core_stall, mem_addr, mem_wdata, host_addr, host_wdata);
      end
      tick;
    end
    host_req = 1'b0;
    #1;
    checks++;
    if (host_gnt !== 1'b0 || core_gnt !== 1'b0 || mem_we !== 1'b0 || core_stall !== 1'b1) begin
      errors++;
      $display("FAIL burst_end got gnt=%b%b we=%b stall=%b want 00 0 1", core_gnt, host_gnt, mem_we, core_stall);
    end
    host_we = 1'b0;
    tick;
    checks++;
    if (core_gnt !== 1'b1) begin
      errors++;
      $display("FAIL burst_core_after got %b want 1", core_gnt);
    end
    core_req = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_maxhold;
    int wait_k, want_k;
    core_req = 1'b1;
    core_we = 1'b0;
    host_req = 1'b0;
    tick;
    checks++;
    if (core_gnt !== 1'b1) begin
      errors++;
      $display("FAIL hold_core_gnt got %b want 1", core_gnt);
    end
    host_req = 1'b1;
    host_len = 5'd1;
    host_we = 1'b0;
    wait_k = -1;
    for (int k = 1; k <= 40; k++) begin
      tick;
      if (host_gnt === 1'b1 && wait_k < 0) wait_k = k;
    end
    want_k = RR ? MAXHOLD : -1;
    checks++;
    if (wait_k != want_k) begin
      errors++;
      $display("FAIL hold_preempt got %0d want %0d", wait_k, want_k);
    end
    host_req = 1'b0;
    core_req = 1'b0;
    tick;
    tick;
    tick;
  endtask

  task automatic test_reset_midburst;
    int n;
    RST = 1'b1;
    #1;
    RST = 1'b0;
    host_req = 1'b1;
    host_we = 1'b1;
    host_len = 5'd8;
    core_req = 1'b0;
    tick;
    tick;
    checks++;
    if (host_gnt !== 1'b1 || mem_we !== 1'b1) begin
      errors++;
      $display("FAIL mid_beat2 got gnt=%b we=%b want 1 1", host_gnt, mem_we);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (host_gnt !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_drop got gnt=%b we=%b want 0 0", host_gnt, mem_we);
    end
    tick;
    RST = 1'b0;
    host_len = 5'd3;
    tick;
    n = 0;
    for (int k = 0; k < 20 && host_gnt === 1'b1; k++) begin
      n++;
      tick;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL mid_restart_beats got %0d want 3", n);
    end
    host_req = 1'b0;
    host_we = 1'b0;
    tick;
  endtask

  task automatic model_step;
    int nxt;
    m_crv = m_owner == 1 && core_req && !core_we;
    m_hrv = m_owner == 2 && host_req && !host_we;
    nxt = m_owner;
    if (m_owner == 0) begin
      if (core_req && host_req) nxt = (RR && !m_last_host) ? 2 : 1;
      else nxt = core_req ? 1 : host_req ? 2 : 0;
      m_run = 0;
    end else if (m_owner == 1) begin
      if (!core_req) nxt = 0;
      else if (RR && host_req && m_run >= MAXHOLD - 1) nxt = 2;
      m_run = nxt == 1 ? m_run + 1 : 0;
      if (nxt != 1) m_last_host = 1'b0;
    end else begin
      if (!host_req || m_left == 1) begin
        nxt = 0;
        m_last_host = 1'b1;
      end else if (host_req) m_left = m_left - 1;
    end
    if (m_owner != 2 && nxt == 2) m_left = host_len == 0 ? 1 : int'(host_len);
    m_owner = nxt;
  endtask

  task automatic test_random;
    logic exp_cg, exp_hg, exp_we;
    logic [LANES*AW-1:0] exp_addr;
    logic [LANES*DW-1:0] exp_wdata;
    RST = 1'b1;
    core_req = 1'b0;
    host_req = 1'b0;
    #1;
    RST = 1'b0;
    m_owner = 0;
    m_run = 0;
    m_left = 0;
    m_last_host = 1'b1;
    m_crv = 1'b0;
    m_hrv = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) core_req = ~core_req;
      if ($urandom_range(0, 7) == 0) host_req = ~host_req;
      core_we = 1'($urandom);
      host_we = 1'($urandom);
      core_addr = LANES*AW'({$urandom, $urandom});
      host_addr = LANES*AW'({$urandom, $urandom});
      core_wdata = LANES*DW'({$urandom, $urandom});
      host_wdata = LANES*DW'({$urandom, $urandom});
      host_len = 5'($urandom_range(0, 16));
      #1;
      exp_cg = m_owner == 1;
      exp_hg = m_owner == 2;
      exp_addr = exp_cg ? core_addr : exp_hg ? host_addr : '0;
      exp_wdata = exp_cg ? core_wdata : exp_hg ? host_wdata : '0;
      exp_we = exp_cg ? core_we & core_req : exp_hg ? host_we & host_req : 1'b0;
      checks++;
      if ({core_gnt, host_gnt} !== {exp_cg, exp_hg}) begin
        errors++;
        $display("FAIL rnd_gnt c%0d got %b%b want %b%b", c, core_gnt, host_gnt, exp_cg, exp_hg);
      end
      checks++;
      if (core_stall !== (core_req & ~exp_cg)) begin
        errors++;
        $display("FAIL rnd_stall c%0d got %b want %b", c, core_stall, core_req & ~exp_cg);
      end
      checks++;
      if ({core_rvalid, host_rvalid} !== {m_crv, m_hrv}) begin
        errors++;
        $display("FAIL rnd_rvalid c%0d got %b%b want %b%b", c, core_rvalid, host_rvalid, m_crv, m_hrv);
      end
      checks++;
      if (mem_addr !== exp_addr || mem_wdata !== exp_wdata || mem_we !== exp_we) begin
        errors++;
        $display("FAIL rnd_mem c%0d got %h %h %b want %h %h %b", c, mem_addr, mem_wdata, mem_we, exp_addr, exp_wdata, exp_we);
      end
      model_step;
      tick;
    end
    core_req = 1'b0;
    host_req = 1'b0;
  endtask

  initial begin
    test_reset;
    test_core_read;
    test_tie;
    test_host_burst;
    test_maxhold;
    test_reset_midburst;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
